// File: rtl/alu_ctrl_pipe.sv
`default_nettype none
// ============================================================================
// Module   : alu_ctrl_pipe
// Purpose  : LEGv8 ALU-control decode with registered EX stage, NZCV flag
//            register and EX->ID flag forwarding for B.cond resolution.
// Revision : 1.0  initial release
// ============================================================================
module alu_ctrl_pipe #(
    parameter int                 OP_W      = 11,
    parameter int                 CNTRL_W   = 3,
    parameter bit                 FWD_EN    = 1'b1,
    parameter logic [CNTRL_W-1:0] ILL_CNTRL = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               id_valid,
    input  logic [OP_W-1:0]    id_opcode,
    input  logic               id_alu_on,
    input  logic [3:0]         id_cond,
    input  logic               stall,
    input  logic               flush,
    input  logic               alu_carry,
    input  logic               alu_zero,
    input  logic               alu_overflow,
    input  logic               alu_negative,
    output logic               ex_valid,
    output logic [CNTRL_W-1:0] ex_ALU_cntrl,
    output logic               ex_set_flags,
    output logic               ex_illegal,
    output logic [3:0]         flags,
    output logic [3:0]         fwd_flags,
    output logic               id_is_bcond,
    output logic               cond_met
);

    localparam logic [CNTRL_W-1:0] c_pass = CNTRL_W'(3'b000);
    localparam logic [CNTRL_W-1:0] c_add  = CNTRL_W'(3'b010);
    localparam logic [CNTRL_W-1:0] c_sub  = CNTRL_W'(3'b011);
    localparam logic [CNTRL_W-1:0] c_and  = CNTRL_W'(3'b100);
    localparam logic [CNTRL_W-1:0] c_orr  = CNTRL_W'(3'b101);
    localparam logic [CNTRL_W-1:0] c_eor  = CNTRL_W'(3'b110);

    logic [10:0]        w_op;
    logic [CNTRL_W-1:0] w_cntrl;
    logic               w_set;
    logic               w_ill;
    logic [3:0]         w_alu_flags;
    logic               w_flag_wr;
    logic               w_c, w_z, w_v, w_n;
    logic               w_eval;

    assign w_op        = id_opcode[OP_W-1 -: 11];
    assign w_alu_flags = {alu_carry, alu_zero, alu_overflow, alu_negative};
    assign id_is_bcond = (w_op[10:3] == 8'b01010100);

    always_comb begin
        w_cntrl = ILL_CNTRL;
        w_set   = 1'b0;
        w_ill   = 1'b0;
        casez (w_op)
            11'b10001011000,
            11'b1001000100?,
            11'b11111000010,
            11'b11111000000,
            11'b100101?????: w_cntrl = c_add;
            11'b10101011000: begin
                w_cntrl = c_add;
                w_set   = 1'b1;
            end
            11'b11001011000,
            11'b1101000100?: w_cntrl = c_sub;
            11'b11101011000: begin
                w_cntrl = c_sub;
                w_set   = 1'b1;
            end
            11'b10001010000: w_cntrl = c_and;
            11'b10101010000: w_cntrl = c_orr;
            11'b11001010000: w_cntrl = c_eor;
            11'b11010110000,
            11'b10110100???,
            11'b01010100???,
            11'b000101?????: w_cntrl = c_pass;
            default:         w_ill   = 1'b1;
        endcase
        // ALU-off still keeps a legal opcode legal; it only suppresses the ALU
        if (!id_alu_on) begin
            w_cntrl = ILL_CNTRL;
            w_set   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid     <= 1'b0;
            ex_ALU_cntrl <= ILL_CNTRL;
            ex_set_flags <= 1'b0;
            ex_illegal   <= 1'b0;
        end else if (flush) begin
            ex_valid     <= 1'b0;
            ex_ALU_cntrl <= ILL_CNTRL;
            ex_set_flags <= 1'b0;
            ex_illegal   <= 1'b0;
        end else if (!stall) begin
            ex_valid     <= id_valid;
            ex_ALU_cntrl <= w_cntrl;
            ex_set_flags <= id_valid & w_set;
            ex_illegal   <= id_valid & w_ill;
        end
    end

    // Flags commit only on the edge where the setter actually leaves EX
    assign w_flag_wr = ex_valid & ex_set_flags & ~stall & ~flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags <= 4'b0000;
        end else if (w_flag_wr) begin
            flags <= w_alu_flags;
        end
    end

    generate
        if (FWD_EN) begin : g_fwd
            assign fwd_flags = (ex_valid & ex_set_flags) ? w_alu_flags : flags;
        end else begin : g_no_fwd
            assign fwd_flags = flags;
        end
    endgenerate

    assign w_c = fwd_flags[3];
    assign w_z = fwd_flags[2];
    assign w_v = fwd_flags[1];
    assign w_n = fwd_flags[0];

    always_comb begin
        w_eval = 1'b1;
        case (id_cond)
            4'b0000: w_eval = w_z;
            4'b0001: w_eval = ~w_z;
            4'b0010: w_eval = w_c;
            4'b0011: w_eval = ~w_c;
            4'b0100: w_eval = w_n;
            4'b0101: w_eval = ~w_n;
            4'b0110: w_eval = w_v;
            4'b0111: w_eval = ~w_v;
            4'b1000: w_eval = w_c & ~w_z;
            4'b1001: w_eval = ~(w_c & ~w_z);
            4'b1010: w_eval = (w_n == w_v);
            4'b1011: w_eval = (w_n != w_v);
            4'b1100: w_eval = ~w_z & (w_n == w_v);
            4'b1101: w_eval = ~(~w_z & (w_n == w_v));
            default: w_eval = 1'b1;
        endcase
    end

    // Gated by reset so a pending branch drops as soon as reset asserts
    assign cond_met = id_valid & id_is_bcond & w_eval & ~reset;

endmodule
`default_nettype wire

// File: tb/tb_alu_ctrl_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_ctrl_pipe
// Purpose  : Self-checking bench for alu_ctrl_pipe (forwarding on and off).
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_ctrl_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, id_valid, id_alu_on, stall, flush;
    logic        alu_carry, alu_zero, alu_overflow, alu_negative;
    logic [10:0] id_opcode;
    logic [3:0]  id_cond;

    logic       a_ex_valid, a_ex_set, a_ex_ill, a_bcond, a_cond;
    logic [2:0] a_ex_cntrl;
    logic [3:0] a_flags, a_fwd;
    logic       b_ex_valid, b_ex_set, b_ex_ill, b_bcond, b_cond;
    logic [2:0] b_ex_cntrl;
    logic [3:0] b_flags, b_fwd;

    alu_ctrl_pipe #(.OP_W(11), .CNTRL_W(3), .FWD_EN(1'b1), .ILL_CNTRL(3'b000)) dut_fwd (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_alu_on(id_alu_on), .id_cond(id_cond), .stall(stall), .flush(flush),
        .alu_carry(alu_carry), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
        .alu_negative(alu_negative), .ex_valid(a_ex_valid), .ex_ALU_cntrl(a_ex_cntrl),
        .ex_set_flags(a_ex_set), .ex_illegal(a_ex_ill), .flags(a_flags),
        .fwd_flags(a_fwd), .id_is_bcond(a_bcond), .cond_met(a_cond)
    );

    alu_ctrl_pipe #(.OP_W(11), .CNTRL_W(3), .FWD_EN(1'b0), .ILL_CNTRL(3'b000)) dut_nofwd (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_alu_on(id_alu_on), .id_cond(id_cond), .stall(stall), .flush(flush),
        .alu_carry(alu_carry), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
        .alu_negative(alu_negative), .ex_valid(b_ex_valid), .ex_ALU_cntrl(b_ex_cntrl),
        .ex_set_flags(b_ex_set), .ex_illegal(b_ex_ill), .flags(b_flags),
        .fwd_flags(b_fwd), .id_is_bcond(b_bcond), .cond_met(b_cond)
    );

    typedef struct {
        logic [10:0] pat;
        logic [10:0] mask;
        logic [2:0]  code;
        logic        set;
        logic        bc;
    } dec_t;

    typedef struct {
        logic [10:0] op;
        logic        alu_on;
        logic [2:0]  cntrl;
        logic        set;
        logic        ill;
        logic        bc;
    } vec_t;

    dec_t dec_tab[16];
    vec_t vecs[20];

    int checks   = 0;
    int failures = 0;

    // Reference state: what the EX slot and flag register should hold
    logic       m_v, m_s, m_i;
    logic [2:0] m_c;
    logic [3:0] m_flags;

    localparam logic [10:0] OP_ADD   = 11'b10001011000;
    localparam logic [10:0] OP_SUBS  = 11'b11101011000;
    localparam logic [10:0] OP_BCOND = 11'b01010100000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic void ref_decode(input logic [10:0] op, input logic alu_on,
                                       output logic [2:0] c, output logic s,
                                       output logic ill, output logic bc);
        c = 3'b000; s = 1'b0; ill = 1'b1; bc = 1'b0;
        for (int k = 0; k < 16; k++) begin
            if ((op & dec_tab[k].mask) == dec_tab[k].pat) begin
                c = dec_tab[k].code; s = dec_tab[k].set; ill = 1'b0; bc = dec_tab[k].bc;
            end
        end
        if (!alu_on) begin
            c = 3'b000; s = 1'b0;
        end
    endfunction

    // ARM-style evaluation: base test from cond[3:1], inverted by cond[0]
    function automatic logic ref_eval(input logic [3:0] cond, input logic [3:0] f);
        logic c, z, v, n, base;
        c = f[3]; z = f[2]; v = f[1]; n = f[0];
        case (cond[3:1])
            3'd0: base = z;
            3'd1: base = c;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = c & ~z;
            3'd5: base = (n == v);
            3'd6: base = ~z & (n == v);
            default: base = 1'b1;
        endcase
        if (cond == 4'hF) return 1'b1;
        return cond[0] ? ~base : base;
    endfunction

    function automatic logic [3:0] live();
        return {alu_carry, alu_zero, alu_overflow, alu_negative};
    endfunction

    task automatic model_reset();
        m_v = 1'b0; m_s = 1'b0; m_i = 1'b0; m_c = 3'b000; m_flags = 4'b0000;
    endtask

    task automatic drive(input logic v, input logic [10:0] op, input logic on,
                         input logic [3:0] cond, input logic st, input logic fl,
                         input logic [3:0] f);
        id_valid = v; id_opcode = op; id_alu_on = on; id_cond = cond;
        stall = st; flush = fl;
        {alu_carry, alu_zero, alu_overflow, alu_negative} = f;
    endtask

    task automatic tick();
        logic [2:0] c;
        logic s, ill, bc, st, fl, v;
        logic [3:0] lf;
        ref_decode(id_opcode, id_alu_on, c, s, ill, bc);
        st = stall; fl = flush; v = id_valid; lf = live();
        @(posedge clk);
        if (reset) begin
            model_reset();
        end else begin
            if (m_v && m_s && !st && !fl) m_flags = lf;
            if (fl) begin
                m_v = 1'b0; m_s = 1'b0; m_i = 1'b0; m_c = 3'b000;
            end else if (!st) begin
                m_v = v; m_c = c; m_s = v & s; m_i = v & ill;
            end
        end
        #1;
    endtask

    task automatic check_all(input string tag);
        logic [2:0] c;
        logic s, ill, bc;
        logic [3:0] fa, fb;
        ref_decode(id_opcode, id_alu_on, c, s, ill, bc);
        fa = (m_v && m_s) ? live() : m_flags;
        fb = m_flags;
        chk({tag, ".ex_valid"}, a_ex_valid, m_v);
        chk({tag, ".ex_set"},   a_ex_set,   m_s);
        chk({tag, ".ex_ill"},   a_ex_ill,   m_i);
        if (m_v) chk({tag, ".ex_cntrl"}, a_ex_cntrl, m_c);
        chk({tag, ".flags"},    a_flags,    m_flags);
        chk({tag, ".fwd"},      a_fwd,      fa);
        chk({tag, ".bcond"},    a_bcond,    bc);
        chk({tag, ".cond"},     a_cond,     !reset & id_valid & bc & ref_eval(id_cond, fa));
        chk({tag, ".nf_ex_valid"}, b_ex_valid, m_v);
        chk({tag, ".nf_flags"}, b_flags,    m_flags);
        chk({tag, ".nf_fwd"},   b_fwd,      fb);
        chk({tag, ".nf_cond"},  b_cond,     !reset & id_valid & bc & ref_eval(id_cond, fb));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [10:0] ops[16];
        logic [3:0]  f;

        dec_tab[0]  = '{11'b10001011000, 11'h7FF, 3'd2, 1'b0, 1'b0};
        dec_tab[1]  = '{11'b10101011000, 11'h7FF, 3'd2, 1'b1, 1'b0};
        dec_tab[2]  = '{11'b10010001000, 11'h7FE, 3'd2, 1'b0, 1'b0};
        dec_tab[3]  = '{11'b11001011000, 11'h7FF, 3'd3, 1'b0, 1'b0};
        dec_tab[4]  = '{11'b11101011000, 11'h7FF, 3'd3, 1'b1, 1'b0};
        dec_tab[5]  = '{11'b11010001000, 11'h7FE, 3'd3, 1'b0, 1'b0};
        dec_tab[6]  = '{11'b10001010000, 11'h7FF, 3'd4, 1'b0, 1'b0};
        dec_tab[7]  = '{11'b10101010000, 11'h7FF, 3'd5, 1'b0, 1'b0};
        dec_tab[8]  = '{11'b11001010000, 11'h7FF, 3'd6, 1'b0, 1'b0};
        dec_tab[9]  = '{11'b11111000010, 11'h7FF, 3'd2, 1'b0, 1'b0};
        dec_tab[10] = '{11'b11111000000, 11'h7FF, 3'd2, 1'b0, 1'b0};
        dec_tab[11] = '{11'b10010100000, 11'h7E0, 3'd2, 1'b0, 1'b0};
        dec_tab[12] = '{11'b11010110000, 11'h7FF, 3'd0, 1'b0, 1'b0};
        dec_tab[13] = '{11'b10110100000, 11'h7F8, 3'd0, 1'b0, 1'b0};
        dec_tab[14] = '{11'b01010100000, 11'h7F8, 3'd0, 1'b0, 1'b1};
        dec_tab[15] = '{11'b00010100000, 11'h7E0, 3'd0, 1'b0, 1'b0};

        vecs[0]  = '{11'b10001011000, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{11'b10101011000, 1'b1, 3'd2, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{11'b10010001001, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{11'b11001011000, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{11'b11101011000, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{11'b11010001000, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{11'b10001010000, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{11'b10101010000, 1'b1, 3'd5, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{11'b11001010000, 1'b1, 3'd6, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{11'b11111000010, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{11'b11111000000, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{11'b10010110101, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{11'b11010110000, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{11'b10110100111, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{11'b01010100011, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1};
        vecs[15] = '{11'b00010111111, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0};
        vecs[16] = '{11'b11111111111, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0};
        vecs[17] = '{11'b11111000010, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0};
        vecs[18] = '{11'b10101011000, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0};
        vecs[19] = '{11'b10001011001, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0};

        for (int k = 0; k < 16; k++) ops[k] = vecs[k].op;

        reset = 1'b1;
        drive(1'b0, 11'b0, 1'b1, 4'h0, 1'b0, 1'b0, 4'h0);
        model_reset();
        #2;
        chk("reset.ex_cntrl", a_ex_cntrl, 3'b000);
        check_all("reset");
        tick();
        @(negedge clk);
        reset = 1'b0;

        // Decode sweep
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, vecs[i].op, vecs[i].alu_on, 4'h0, 1'b0, 1'b0, 4'($urandom_range(0, 15)));
            #1;
            chk($sformatf("dec%0d.bcond", i), a_bcond, vecs[i].bc);
            check_all($sformatf("dec%0d.id", i));
            tick();
            chk($sformatf("dec%0d.valid", i), a_ex_valid, 1'b1);
            chk($sformatf("dec%0d.cntrl", i), a_ex_cntrl, vecs[i].cntrl);
            chk($sformatf("dec%0d.set", i),   a_ex_set,   vecs[i].set);
            chk($sformatf("dec%0d.ill", i),   a_ex_ill,   vecs[i].ill);
            check_all($sformatf("dec%0d.ex", i));
        end

        // Set-flags selectivity
        drive(1'b1, OP_SUBS, 1'b1, 4'h0, 1'b0, 1'b0, 4'b0000); #1; tick();
        drive(1'b0, OP_ADD, 1'b1, 4'h0, 1'b0, 1'b0, 4'b0110); #1;
        chk("sel.fwd", a_fwd, 4'b0110);
        tick();
        chk("sel.subs_flags", a_flags, 4'b0110);
        drive(1'b1, OP_ADD, 1'b1, 4'h0, 1'b0, 1'b0, 4'b0000); #1; tick();
        drive(1'b0, OP_ADD, 1'b1, 4'h0, 1'b0, 1'b0, 4'b1111); #1;
        check_all("sel.add_ex");
        tick();
        chk("sel.add_flags", a_flags, 4'b0110);

        // Asynchronous reset mid-cycle with a flag setter in EX
        drive(1'b1, OP_SUBS, 1'b1, 4'h0, 1'b0, 1'b0, 4'b1001); #1; tick();
        drive(1'b1, OP_BCOND, 1'b1, 4'b0001, 1'b0, 1'b0, 4'b1001);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        chk("rst.flags", a_flags, 4'b0000);
        chk("rst.ex_valid", a_ex_valid, 1'b0);
        chk("rst.ex_cntrl", a_ex_cntrl, 3'b000);
        chk("rst.cond", a_cond, 1'b0);
        check_all("rst");
        tick();
        @(negedge clk);
        reset = 1'b0;

        // Forwarding: SUBS in EX with live N=1,V=0, B.LT in ID
        drive(1'b1, OP_SUBS, 1'b1, 4'h0, 1'b0, 1'b0, 4'b0000); #1; tick();
        drive(1'b1, OP_BCOND, 1'b1, 4'b1011, 1'b0, 1'b0, 4'b0001); #1;
        chk("fwd.cond_on", a_cond, 1'b1);
        chk("fwd.cond_off", b_cond, 1'b0);
        chk("fwd.nf_fwd", b_fwd, 4'b0000);
        check_all("fwd");

        // Stall three cycles with SUBS held in EX
        for (int i = 0; i < 3; i++) begin
            f = 4'($urandom_range(0, 15));
            drive(1'b1, OP_ADD, 1'b1, 4'h0, 1'b1, 1'b0, f); #1;
            chk("stall.fwd", a_fwd, f);
            chk("stall.cntrl", a_ex_cntrl, 3'b011);
            chk("stall.set", a_ex_set, 1'b1);
            check_all("stall");
            tick();
            chk("stall.flags_held", a_flags, 4'b0000);
        end
        drive(1'b0, OP_ADD, 1'b1, 4'h0, 1'b0, 1'b0, 4'b1010); #1; tick();
        chk("stall.release_write", a_flags, 4'b1010);
        drive(1'b0, OP_ADD, 1'b1, 4'h0, 1'b0, 1'b0, 4'b0101); #1; tick();
        chk("stall.single_write", a_flags, 4'b1010);

        // Flush together with stall cancels the write
        drive(1'b1, OP_SUBS, 1'b1, 4'h0, 1'b0, 1'b0, 4'b0000); #1; tick();
        drive(1'b0, OP_ADD, 1'b1, 4'h0, 1'b1, 1'b1, 4'b1111); #1; tick();
        chk("flush.ex_valid", a_ex_valid, 1'b0);
        chk("flush.flags", a_flags, 4'b1010);
        drive(1'b0, OP_ADD, 1'b1, 4'h0, 1'b0, 1'b0, 4'b1111); #1; tick();
        chk("flush.flags_after", a_flags, 4'b1010);
        check_all("flush");

        // Condition sweep: SUBS stalled in EX forwards every live NZCV value
        drive(1'b1, OP_SUBS, 1'b1, 4'h0, 1'b0, 1'b0, 4'b0000); #1; tick();
        for (int fv = 0; fv < 16; fv++) begin
            for (int cc = 0; cc < 16; cc++) begin
                drive(1'b1, OP_BCOND | 11'(cc & 7), 1'b1, 4'(cc), 1'b1, 1'b0, 4'(fv)); #1;
                chk($sformatf("cond.f%0d.c%0d", fv, cc), a_cond, ref_eval(4'(cc), 4'(fv)));
                chk($sformatf("cond.nf.f%0d.c%0d", fv, cc), b_cond, ref_eval(4'(cc), m_flags));
                if (cc >= 14) chk($sformatf("cond.al.f%0d.c%0d", fv, cc), a_cond, 1'b1);
                tick();
            end
        end

        // Randomised traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 9) != 0),
                  ($urandom_range(0, 5) == 0) ? 11'($urandom) : ops[$urandom_range(0, 15)],
                  ($urandom_range(0, 7) != 0),
                  4'($urandom_range(0, 15)),
                  ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 9) == 0),
                  4'($urandom_range(0, 15)));
            #1;
            check_all($sformatf("rnd%0d", i));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
